// File: rtl/npc_mc_seq_pkg.sv
// Shared definitions for the npc multi-cycle sequencer: state encoding, instruction size, reset PC.
package npc_mc_seq_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam int unsigned INST_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_WAIT  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   // EXU control results captured on exec_done
   typedef struct packed {
      logic jump;
      logic ebreak;
   } exu_flags_t;

endpackage

// File: rtl/npc_mc_seq_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts STAGES clock edges after arst_n rises.
module npc_mc_seq_rst_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   output logic rst_n
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], 1'b1};
      end
   end

   assign rst_n = sync_q[STAGES-1];

endmodule

// File: rtl/npc_mc_seq.sv
// Multi-cycle npc sequencer: FETCH->WAIT->EXEC->WB over a valid/ready imem handshake, halts on ebreak.
// Optional performance counters are built when NPC_PERF_CNT_EN is defined.
module npc_mc_seq
   import npc_mc_seq_pkg::*;
#(
   parameter int unsigned          DATA_LEN        = XLEN_DEFAULT,
   parameter logic [DATA_LEN-1:0]  RESET_PC        = DATA_LEN'(DEFAULT_RESET_PC),
   parameter int unsigned          RST_SYNC_STAGES = 2
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [DATA_LEN-1:0] imem_addr,
   input  logic                imem_rsp_valid,
   input  logic [DATA_LEN-1:0] imem_rsp_data,
   output logic [DATA_LEN-1:0] pc_out,
   output logic [DATA_LEN-1:0] inst_out,
   output logic                exec_start,
   input  logic                exec_done,
   input  logic                jump_flag,
   input  logic [DATA_LEN-1:0] jump_pc,
   input  logic                ebreak,
   output logic                wb_en,
   output logic                halted
`ifdef NPC_PERF_CNT_EN
   ,
   output logic [63:0]         cycle_cnt,
   output logic [63:0]         instret_cnt
`endif
);

   logic                rst_n;
   state_e              state;
   state_e              state_d;
   logic [DATA_LEN-1:0] pc_d;
   logic [DATA_LEN-1:0] inst_d;
   logic [DATA_LEN-1:0] jump_pc_q;
   logic [DATA_LEN-1:0] jump_pc_d;
   exu_flags_t          flags_q;
   exu_flags_t          flags_d;
   logic                exec_start_d;
   logic                wb_en_d;
   logic                halted_d;

   npc_mc_seq_rst_sync #(
      .STAGES (RST_SYNC_STAGES)
   ) u_rst_sync (
      .clk    (sys_clk),
      .arst_n (sys_rst_n),
      .rst_n  (rst_n)
   );

   // Request is a pure decode of state and PC so the address is stable for the whole FETCH
   assign imem_req_valid = rst_n && (state == ST_FETCH);
   assign imem_addr      = pc_out;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d      = state;
      pc_d         = pc_out;
      inst_d       = inst_out;
      jump_pc_d    = jump_pc_q;
      flags_d      = flags_q;
      exec_start_d = 1'b0;
      wb_en_d      = 1'b0;
      halted_d     = halted;
      case (state)
         ST_FETCH: begin
            if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               inst_d       = imem_rsp_data;
               exec_start_d = 1'b1;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               flags_d.jump   = jump_flag;
               flags_d.ebreak = ebreak;
               jump_pc_d      = jump_pc;
               wb_en_d        = !ebreak;
               state_d        = ST_WB;
            end
         end
         ST_WB: begin
            // ebreak takes priority over a jump and leaves the PC on the ebreak itself
            if (flags_q.ebreak) begin
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               pc_d    = flags_q.jump ? (jump_pc_q & ~DATA_LEN'(1))
                                      : pc_out + DATA_LEN'(INST_BYTES);
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out     <= RESET_PC;
         inst_out   <= '0;
         jump_pc_q  <= '0;
         flags_q    <= '0;
         exec_start <= 1'b0;
         wb_en      <= 1'b0;
         halted     <= 1'b0;
      end else begin
         pc_out     <= pc_d;
         inst_out   <= inst_d;
         jump_pc_q  <= jump_pc_d;
         flags_q    <= flags_d;
         exec_start <= exec_start_d;
         wb_en      <= wb_en_d;
         halted     <= halted_d;
      end
   end

`ifdef NPC_PERF_CNT_EN
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (!halted) begin
            cycle_cnt <= cycle_cnt + 64'd1;
         end
         if (wb_en) begin
            instret_cnt <= instret_cnt + 64'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_npc_mc_seq.sv
// Directed bench for npc_mc_seq: default-PC instance plus a wrap-around RESET_PC instance on shared stimulus.
`timescale 1ns/1ps
module tb_npc_mc_seq;

   localparam int unsigned SYNC = 2;

   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        exec_done = 1'b0;
   logic        jump_flag = 1'b0;
   logic [31:0] jump_pc = '0;
   logic        ebreak = 1'b0;

   logic        a_req_valid, a_exec_start, a_wb_en, a_halted;
   logic [31:0] a_addr, a_pc, a_inst;
   logic        b_req_valid, b_exec_start, b_wb_en, b_halted;
   logic [31:0] b_addr, b_pc, b_inst;
`ifdef NPC_PERF_CNT_EN
   logic [63:0] a_cycle_cnt, a_instret_cnt, b_cycle_cnt, b_instret_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   npc_mc_seq u_a (
      .sys_clk(clk), .sys_rst_n(sys_rst_n),
      .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(a_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .pc_out(a_pc), .inst_out(a_inst), .exec_start(a_exec_start), .exec_done(exec_done),
      .jump_flag(jump_flag), .jump_pc(jump_pc), .ebreak(ebreak),
      .wb_en(a_wb_en), .halted(a_halted)
`ifdef NPC_PERF_CNT_EN
      , .cycle_cnt(a_cycle_cnt), .instret_cnt(a_instret_cnt)
`endif
   );

   npc_mc_seq #(.RESET_PC(32'hFFFF_FFFC)) u_b (
      .sys_clk(clk), .sys_rst_n(sys_rst_n),
      .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(b_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .pc_out(b_pc), .inst_out(b_inst), .exec_start(b_exec_start), .exec_done(exec_done),
      .jump_flag(jump_flag), .jump_pc(jump_pc), .ebreak(ebreak),
      .wb_en(b_wb_en), .halted(b_halted)
`ifdef NPC_PERF_CNT_EN
      , .cycle_cnt(b_cycle_cnt), .instret_cnt(b_instret_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n;
      #2 sys_rst_n = 1'b0;
      repeat (5) tick();
      vectors++; if (a_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b want 0", a_req_valid); end
      vectors++; if (a_pc !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_pc: got %h want 80000000", a_pc); end
      vectors++; if (a_inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h want 0", a_inst); end
      vectors++; if ({a_exec_start, a_wb_en, a_halted} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes: got %b want 000", {a_exec_start, a_wb_en, a_halted}); end
      vectors++; if (b_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL rst_pc_b: got %h want fffffffc", b_pc); end
`ifdef NPC_PERF_CNT_EN
      vectors++; if (a_cycle_cnt !== 64'd0 || a_instret_cnt !== 64'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", a_cycle_cnt, a_instret_cnt); end
`endif
      sys_rst_n = 1'b1;
      n = 0;
      while (a_req_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++; if (n != SYNC) begin miscompares++; $display("FAIL rst_release_latency: got %0d cycles want %0d", n, SYNC); end
      vectors++; if (a_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL first_addr: got %h want 80000000", a_addr); end
   endtask

   task automatic test_single();
      imem_req_ready = 1'b1;
      tick();
      vectors++; if (a_req_valid !== 1'b0) begin miscompares++; $display("FAIL wait_req_valid: got %b want 0", a_req_valid); end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0010_0093;
      tick();
      imem_rsp_valid = 1'b0;
      exec_done      = 1'b1;
      vectors++; if (a_exec_start !== 1'b1) begin miscompares++; $display("FAIL exec_start_pulse: got %b want 1", a_exec_start); end
      vectors++; if (a_inst !== 32'h0010_0093) begin miscompares++; $display("FAIL inst_latch: got %h want 00100093", a_inst); end
      tick();
      exec_done = 1'b0;
      vectors++; if (a_wb_en !== 1'b1) begin miscompares++; $display("FAIL wb_cycle4: got %b want 1", a_wb_en); end
      vectors++; if (a_pc !== 32'h8000_0000) begin miscompares++; $display("FAIL pc_in_wb: got %h want 80000000", a_pc); end
      tick();
      vectors++; if (a_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL next_addr: got %h want 80000004", a_addr); end
      vectors++; if (a_req_valid !== 1'b1 || a_wb_en !== 1'b0) begin miscompares++; $display("FAIL refetch: got valid=%b wb=%b want 1/0", a_req_valid, a_wb_en); end
      vectors++; if (b_addr !== 32'h0000_0000) begin miscompares++; $display("FAIL pc_wrap: got %h want 00000000", b_addr); end
`ifdef NPC_PERF_CNT_EN
      vectors++; if (a_instret_cnt !== 64'd1) begin miscompares++; $display("FAIL instret_one: got %0d want 1", a_instret_cnt); end
      vectors++; if (a_cycle_cnt !== 64'd4) begin miscompares++; $display("FAIL cycle_cnt: got %0d want 4", a_cycle_cnt); end
`endif
   endtask

   task automatic test_backpressure();
      int wb_seen = 0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         wb_seen += int'(a_wb_en);
         vectors++; if (a_req_valid !== 1'b1 || a_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL fetch_stall[%0d]: got valid=%b addr=%h want 1/80000004", i, a_req_valid, a_addr); end
      end
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      vectors++; if (a_inst !== 32'h0010_0093) begin miscompares++; $display("FAIL rsp_ignored_in_fetch: got %h want 00100093", a_inst); end
      for (int i = 0; i < 5; i++) begin
         tick();
         wb_seen += int'(a_wb_en);
         vectors++; if (a_exec_start !== 1'b0 || a_req_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_stall[%0d]: got start=%b valid=%b want 0/0", i, a_exec_start, a_req_valid); end
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0020_0113;
      tick();
      imem_rsp_valid = 1'b0;
      vectors++; if (a_exec_start !== 1'b1 || a_inst !== 32'h0020_0113) begin miscompares++; $display("FAIL late_rsp_exec: got start=%b inst=%h want 1/00200113", a_exec_start, a_inst); end
      tick();
      wb_seen += int'(a_wb_en);
      vectors++; if (a_exec_start !== 1'b0 || a_inst !== 32'h0020_0113) begin miscompares++; $display("FAIL exec_hold: got start=%b inst=%h want 0/00200113", a_exec_start, a_inst); end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      wb_seen += int'(a_wb_en);
      repeat (2) begin
         tick();
         wb_seen += int'(a_wb_en);
      end
      vectors++; if (wb_seen != 1) begin miscompares++; $display("FAIL wb_count: got %0d want 1", wb_seen); end
      vectors++; if (a_pc !== 32'h8000_0008) begin miscompares++; $display("FAIL pc_after_stall: got %h want 80000008", a_pc); end
   endtask

   task automatic test_jump();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_006F;
      tick();
      imem_rsp_valid = 1'b0;
      exec_done = 1'b1;
      jump_flag = 1'b1;
      jump_pc   = 32'h8000_0101;
      tick();
      exec_done = 1'b0;
      jump_flag = 1'b0;
      jump_pc   = 32'h0;
      vectors++; if (a_wb_en !== 1'b1) begin miscompares++; $display("FAIL jump_wb: got %b want 1", a_wb_en); end
      tick();
      vectors++; if (a_pc !== 32'h8000_0100 || a_addr !== 32'h8000_0100) begin miscompares++; $display("FAIL jump_target: got pc=%h addr=%h want 80000100", a_pc, a_addr); end
   endtask

   task automatic test_ebreak();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0010_0073;
      tick();
      imem_rsp_valid = 1'b0;
      exec_done = 1'b1;
      jump_flag = 1'b1;
      ebreak    = 1'b1;
      jump_pc   = 32'h1234_5678;
      tick();
      exec_done = 1'b0;
      jump_flag = 1'b0;
      ebreak    = 1'b0;
      vectors++; if (a_wb_en !== 1'b0 || a_halted !== 1'b0) begin miscompares++; $display("FAIL ebreak_wb: got wb=%b halted=%b want 0/0", a_wb_en, a_halted); end
      tick();
      vectors++; if (a_halted !== 1'b1) begin miscompares++; $display("FAIL halted: got %b want 1", a_halted); end
      vectors++; if (a_pc !== 32'h8000_0100) begin miscompares++; $display("FAIL ebreak_pc: got %h want 80000100", a_pc); end
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      exec_done      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++; if ({a_req_valid, a_exec_start, a_wb_en, a_halted} !== 4'b0001) begin miscompares++; $display("FAIL halt_quiet[%0d]: got %b want 0001", i, {a_req_valid, a_exec_start, a_wb_en, a_halted}); end
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      exec_done      = 1'b0;
   endtask

   task automatic test_reset_midop();
      sys_rst_n = 1'b0;
      #1;
      vectors++; if (a_halted !== 1'b0 || a_pc !== 32'h8000_0000 || a_req_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset: got halted=%b pc=%h valid=%b want 0/80000000/0", a_halted, a_pc, a_req_valid); end
      repeat (3) tick();
      sys_rst_n = 1'b1;
      repeat (SYNC) tick();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      sys_rst_n = 1'b0;
      #1;
      vectors++; if ({a_req_valid, a_exec_start, a_wb_en} !== 3'b000 || a_pc !== 32'h8000_0000) begin miscompares++; $display("FAIL midop_reset: got strobes=%b pc=%h want 000/80000000", {a_req_valid, a_exec_start, a_wb_en}, a_pc); end
      imem_rsp_valid = 1'b0;
      repeat (3) tick();
      sys_rst_n = 1'b1;
      repeat (SYNC) tick();
      vectors++; if (b_req_valid !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_fetch0: got valid=%b addr=%h want 1/fffffffc", b_req_valid, b_addr); end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0013;
      tick();
      imem_rsp_valid = 1'b0;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      vectors++; if (b_wb_en !== 1'b1) begin miscompares++; $display("FAIL wrap_wb: got %b want 1", b_wb_en); end
      tick();
      vectors++; if (b_addr !== 32'h0000_0000 || a_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL wrap_next: got b=%h a=%h want 00000000/80000004", b_addr, a_addr); end
`ifdef NPC_PERF_CNT_EN
      vectors++; if (b_instret_cnt !== 64'd1) begin miscompares++; $display("FAIL wrap_instret: got %0d want 1", b_instret_cnt); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_jump();
      test_ebreak();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
